// File: rtl/alu_result_stage.sv
// Two-entry in-order result buffer behind the ALU: stores result + {N,Z,C,V} flags computed at push.
// Optional sticky flag accumulator enabled by defining ALU_STICKY_FLAGS_EN.
module alu_result_stage #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_result,
    input  logic             in_cout,
    input  logic             in_a_msb,
    input  logic             in_b_msb,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [3:0]       out_flags
`ifdef ALU_STICKY_FLAGS_EN
    ,
    input  logic             clr_sticky,
    output logic [3:0]       sticky_flags
`endif
);

    logic [1:0]       count_q, count_d;
    logic [WIDTH-1:0] res0_q, res0_d, res1_q, res1_d;
    logic [3:0]       flg0_q, flg0_d, flg1_q, flg1_d;
    logic [3:0]       new_flags;
    logic             push, pop;

    always_comb begin
        new_flags[3] = in_result[WIDTH-1];
        new_flags[2] = (in_result == '0);
        new_flags[1] = in_cout;
        new_flags[0] = (in_a_msb == (in_b_msb ^ in_sub)) && (in_result[WIDTH-1] != in_a_msb);
    end

    assign in_ready   = rst_n && (count_q != 2'd2);
    assign out_valid  = (count_q != 2'd0);
    assign out_result = res0_q;
    assign out_flags  = flg0_q;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    // Slot 0 is always the head; a pop shifts slot 1 forward and a push lands
    // in the first slot that is free after that shift.
    always_comb begin
        res0_d  = res0_q;
        flg0_d  = flg0_q;
        res1_d  = res1_q;
        flg1_d  = flg1_q;
        count_d = count_q;

        if (pop) begin
            res0_d = res1_q;
            flg0_d = flg1_q;
        end

        if (push) begin
            if ((count_q == 2'd0) || ((count_q == 2'd1) && pop)) begin
                res0_d = in_result;
                flg0_d = new_flags;
            end else begin
                res1_d = in_result;
                flg1_d = new_flags;
            end
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
            res0_q  <= '0;
            flg0_q  <= '0;
            res1_q  <= '0;
            flg1_q  <= '0;
        end else begin
            count_q <= count_d;
            res0_q  <= res0_d;
            flg0_q  <= flg0_d;
            res1_q  <= res1_d;
            flg1_q  <= flg1_d;
        end
    end

`ifdef ALU_STICKY_FLAGS_EN
    logic [3:0] sticky_q, sticky_d;

    always_comb begin
        sticky_d = sticky_q;
        if (clr_sticky) begin
            sticky_d = '0;
        end else if (push) begin
            sticky_d = sticky_q | new_flags;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sticky_q <= '0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign sticky_flags = sticky_q;
`endif

endmodule
